// File: rtl/ctu_clsp_ssiclk_ctl.sv
`default_nettype none
// ============================================================================
// Module   : ctu_clsp_ssiclk_ctl
// Brief    : SSI clock burst controller. Enables the SSI clock generator for a
//            requested number of rising edges, then drains until it is quiet.
// Revision : 1.0 - initial release
// ============================================================================
module ctu_clsp_ssiclk_ctl (
    input  logic       jbus_clk,
    input  logic       io_pwron_rst_l,
    input  logic       ssi_req,
    input  logic [7:0] ssi_len,
    input  logic       ssi_abort,
    input  logic       ctu_jbi_ssiclk,
    output logic       ssiclk_enable,
    output logic       ssi_ack,
    output logic       ssi_done,
    output logic       ssi_busy,
    output logic       ssi_err,
    output logic [7:0] ssi_edge_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] c_drain_last = 4'hF;

    state_t     r_state;
    state_t     w_next;
    logic       r_fb;
    logic [7:0] r_len;
    logic [3:0] r_drain_tmr;

    logic w_rise;
    logic w_quiet;
    logic w_timeout;
    logic w_last_edge;
    logic w_accept;

    assign w_rise      = ctu_jbi_ssiclk & ~r_fb;
    assign w_quiet     = ~r_fb & ~ctu_jbi_ssiclk;
    assign w_timeout   = (r_drain_tmr == c_drain_last);
    // 9-bit compare so a saturated count of 255 can never alias onto a length
    assign w_last_edge = w_rise && (({1'b0, ssi_edge_cnt} + 9'd1) == {1'b0, r_len});
    assign w_accept    = (r_state == ST_IDLE) && ssi_req;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (ssi_req) w_next = (ssi_len != 8'd0) ? ST_RUN : ST_DONE;
            ST_RUN:   if (w_last_edge || ssi_abort) w_next = ST_DRAIN;
            ST_DRAIN: if (w_quiet || w_timeout) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge jbus_clk or negedge io_pwron_rst_l) begin
        if (!io_pwron_rst_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Status outputs are flops decoded from the next state so they line up
    // with the state they describe and never glitch.
    always_ff @(posedge jbus_clk or negedge io_pwron_rst_l) begin
        if (!io_pwron_rst_l) begin
            r_fb          <= 1'b0;
            r_len         <= 8'd0;
            r_drain_tmr   <= 4'd0;
            ssiclk_enable <= 1'b0;
            ssi_ack       <= 1'b0;
            ssi_done      <= 1'b0;
            ssi_busy      <= 1'b0;
            ssi_err       <= 1'b0;
            ssi_edge_cnt  <= 8'd0;
        end else begin
            r_fb          <= ctu_jbi_ssiclk;
            ssiclk_enable <= (w_next == ST_RUN);
            ssi_ack       <= w_accept;
            ssi_done      <= (w_next == ST_DONE);
            ssi_busy      <= (w_next != ST_IDLE);

            if (w_accept) begin
                r_len        <= ssi_len;
                ssi_edge_cnt <= 8'd0;
                ssi_err      <= 1'b0;
            end else if ((r_state != ST_IDLE) && w_rise && (ssi_edge_cnt != 8'hFF)) begin
                ssi_edge_cnt <= ssi_edge_cnt + 8'd1;
            end

            if ((r_state == ST_DRAIN) && !w_quiet && w_timeout) begin
                ssi_err <= 1'b1;
            end

            // Held at zero outside DRAIN, so it is already clear on entry
            if (r_state != ST_DRAIN) begin
                r_drain_tmr <= 4'd0;
            end else if (!w_timeout) begin
                r_drain_tmr <= r_drain_tmr + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ctu_clsp_ssiclk_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctu_clsp_ssiclk_ctl
// Brief    : Directed self-checking bench for the SSI clock burst controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctu_clsp_ssiclk_ctl;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [7:0] len;
    logic       abort;
    logic       fb;
    logic       en;
    logic       ack;
    logic       done;
    logic       busy;
    logic       err;
    logic [7:0] cnt;

    int checks;
    int errors;

    ctu_clsp_ssiclk_ctl u_dut (
        .jbus_clk       (clk),
        .io_pwron_rst_l (rst_n),
        .ssi_req        (req),
        .ssi_len        (len),
        .ssi_abort      (abort),
        .ctu_jbi_ssiclk (fb),
        .ssiclk_enable  (en),
        .ssi_ack        (ack),
        .ssi_done       (done),
        .ssi_busy       (busy),
        .ssi_err        (err),
        .ssi_edge_cnt   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 1'b0;
        len    = 8'd0;
        abort  = 1'b0;
        fb     = 1'b0;

        #1;
        chk("rst_en",   32'(en),   32'd0);
        chk("rst_ack",  32'(ack),  32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err",  32'(err),  32'd0);
        chk("rst_cnt",  32'(cnt),  32'd0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Burst of 3 with feedback toggling every 2 cycles
        req = 1'b1; len = 8'd3; fb = 1'b0;
        tick();
        chk("b3_ack",  32'(ack),  32'd1);
        chk("b3_en0",  32'(en),   32'd1);
        chk("b3_busy", 32'(busy), 32'd1);
        chk("b3_cnt0", 32'(cnt),  32'd0);
        req = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            fb = (((i - 1) % 4) < 2);
            tick();
            chk("b3_en",  32'(en),  (i < 9) ? 32'd1 : 32'd0);
            chk("b3_cnt", 32'(cnt), 32'((i + 3) / 4));
            if (i == 1) chk("b3_ack_once", 32'(ack), 32'd0);
        end
        fb = 1'b1; tick();
        chk("b3_drain1", 32'(done), 32'd0);
        fb = 1'b0; tick();
        chk("b3_drain2", 32'(done), 32'd0);
        tick();
        chk("b3_done",    32'(done), 32'd1);
        chk("b3_busy_dn", 32'(busy), 32'd1);
        chk("b3_cnt_dn",  32'(cnt),  32'd3);
        chk("b3_err",     32'(err),  32'd0);
        tick();
        chk("b3_done_off", 32'(done), 32'd0);
        chk("b3_idle",     32'(busy), 32'd0);
        chk("b3_cnt_hold", 32'(cnt),  32'd3);

        // Zero-length burst goes straight to DONE
        req = 1'b1; len = 8'd0;
        tick();
        chk("z_ack",  32'(ack),  32'd1);
        chk("z_done", 32'(done), 32'd1);
        chk("z_en",   32'(en),   32'd0);
        chk("z_cnt",  32'(cnt),  32'd0);
        req = 1'b0;
        tick();
        chk("z_done_off", 32'(done), 32'd0);
        chk("z_en2",      32'(en),   32'd0);
        chk("z_idle",     32'(busy), 32'd0);

        // Abort is ignored while idle
        abort = 1'b1;
        tick();
        chk("ab_idle", 32'(busy), 32'd0);
        abort = 1'b0;

        // Long burst aborted after 5 rises
        req = 1'b1; len = 8'd200;
        tick();
        chk("ab_ack", 32'(ack), 32'd1);
        req = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            fb = (((i - 1) % 4) < 2);
            tick();
        end
        chk("ab_en_pre",  32'(en),  32'd1);
        chk("ab_cnt_pre", 32'(cnt), 32'd5);
        fb = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_en_drop", 32'(en),   32'd0);
        chk("ab_busy",    32'(busy), 32'd1);
        chk("ab_cnt",     32'(cnt),  32'd5);
        fb = 1'b0; tick();
        chk("ab_drain", 32'(done), 32'd0);
        tick();
        chk("ab_done",     32'(done), 32'd1);
        chk("ab_cnt_done", 32'(cnt),  32'd5);
        chk("ab_err",      32'(err),  32'd0);
        tick();
        chk("ab_idle2", 32'(busy), 32'd0);

        // Feedback stuck high in DRAIN -> timeout after 16 cycles
        req = 1'b1; len = 8'd1; fb = 1'b0;
        tick();
        req = 1'b0; fb = 1'b1;
        tick();
        chk("to_en", 32'(en), 32'd0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("to_wait", 32'(done), 32'd0);
        end
        tick();
        chk("to_done", 32'(done), 32'd1);
        chk("to_err",  32'(err),  32'd1);
        chk("to_cnt",  32'(cnt),  32'd1);
        fb = 1'b0;
        tick();
        chk("to_idle", 32'(busy), 32'd0);
        tick();
        chk("to_err_hold", 32'(err), 32'd1);

        // Request held high: back-to-back zero-length bursts
        req = 1'b1; len = 8'd0;
        tick();
        chk("bb_ack1",  32'(ack),  32'd1);
        chk("bb_done1", 32'(done), 32'd1);
        chk("bb_err",   32'(err),  32'd0);
        tick();
        chk("bb_gap_ack",  32'(ack),  32'd0);
        chk("bb_gap_busy", 32'(busy), 32'd0);
        tick();
        chk("bb_ack2",  32'(ack),  32'd1);
        chk("bb_done2", 32'(done), 32'd1);
        req = 1'b0;
        tick();
        chk("bb_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of RUN
        req = 1'b1; len = 8'd10; fb = 1'b0;
        tick();
        req = 1'b0; fb = 1'b1;
        tick();
        chk("rr_en_pre",  32'(en),  32'd1);
        chk("rr_cnt_pre", 32'(cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_en",   32'(en),   32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_ack",  32'(ack),  32'd0);
        chk("rr_done", 32'(done), 32'd0);
        chk("rr_cnt",  32'(cnt),  32'd0);
        chk("rr_err",  32'(err),  32'd0);
        fb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rr_hold_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("rr_post_done", 32'(done), 32'd0);
        chk("rr_post_busy", 32'(busy), 32'd0);
        req = 1'b1; len = 8'd1;
        tick();
        chk("rr_ack_new", 32'(ack), 32'd1);
        chk("rr_en_new",  32'(en),  32'd1);
        req = 1'b0; fb = 1'b1;
        tick();
        chk("rr_cnt_new", 32'(cnt), 32'd1);
        chk("rr_en_off",  32'(en),  32'd0);
        fb = 1'b0;
        tick();
        tick();
        chk("rr_done_new", 32'(done), 32'd1);
        chk("rr_err_new",  32'(err),  32'd0);
        tick();
        chk("rr_idle_new", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
